// File: rtl/vga_pixel_out.sv
// vga_pixel_out: framebuffer read requests plus latency-matched RGB444/sync pins.
// Define TEST_PATTERN_EN to add the pattern_sel colour-bar generator.
module vga_pixel_out #(
    parameter int RD_LATENCY   = 1,
    parameter int SCALE_SHIFT  = 2,
    parameter bit SYNC_POL     = 1'b1,
    parameter int H_VIS        = 800,
    parameter int H_SYNC_START = 840,
    parameter int H_SYNC_END   = 968,
    parameter int H_TOTAL      = 1056,
    parameter int V_VIS        = 600,
    parameter int V_SYNC_START = 601,
    parameter int V_SYNC_END   = 605,
    parameter int V_TOTAL      = 628
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [$clog2((H_VIS>>SCALE_SHIFT)*(V_VIS>>SCALE_SHIFT))-1:0] fb_addr,
    output logic        fb_rd_en,
    input  logic [11:0] fb_data,
    input  logic        pattern_sel,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start
);
    localparam int FB_W = H_VIS >> SCALE_SHIFT;
    localparam int AW   = $clog2(FB_W * (V_VIS >> SCALE_SHIFT));
    localparam int XW   = $clog2(FB_W);
    localparam int ND   = RD_LATENCY + 1;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic frm;
`ifdef TEST_PATTERN_EN
        logic pat;
        logic [XW-1:0] x;
`endif
    } tap_t;

    logic          vis_s0;
    logic          hs_s0;
    logic          vs_s0;
    logic          origin;
    logic          rd_s0;
    logic          line_end;
    logic          frame_end;
    logic          fb_row_end;
    logic [XW-1:0] x_s0;
    logic [AW-1:0] line_base;
    logic [AW-1:0] base_eff;
    logic [9:0]    vmask;
    tap_t          tap_s0;
    tap_t          dl [ND];
    tap_t          tap_o;
    logic [11:0]   pix;

    assign vmask = 10'((1 << SCALE_SHIFT) - 1);

    always_comb begin
        vis_s0     = (hcount < 11'(H_VIS)) && (vcount < 10'(V_VIS));
        hs_s0      = (hcount >= 11'(H_SYNC_START)) && (hcount < 11'(H_SYNC_END));
        vs_s0      = (vcount >= 10'(V_SYNC_START)) && (vcount < 10'(V_SYNC_END));
        origin     = (hcount == 11'd0) && (vcount == 10'd0);
        x_s0       = XW'(hcount >> SCALE_SHIFT);
        // origin bypass lets the first pixel after a mid-frame reset land at 0
        base_eff   = origin ? '0 : line_base;
        line_end   = hcount == 11'(H_TOTAL - 1);
        frame_end  = vcount == 10'(V_TOTAL - 1);
        fb_row_end = (vcount < 10'(V_VIS)) && ((vcount & vmask) == vmask);
`ifdef TEST_PATTERN_EN
        rd_s0      = vis_s0 && !pattern_sel;
`else
        rd_s0      = vis_s0;
`endif
    end

    always_comb begin
        tap_s0     = '0;
        tap_s0.vis = vis_s0;
        tap_s0.hs  = hs_s0;
        tap_s0.vs  = vs_s0;
        tap_s0.frm = origin;
`ifdef TEST_PATTERN_EN
        tap_s0.pat = pattern_sel;
        tap_s0.x   = x_s0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_addr   <= '0;
            fb_rd_en  <= 1'b0;
            line_base <= '0;
        end else begin
            fb_rd_en <= rd_s0;
            if (rd_s0)
                fb_addr <= base_eff + AW'(x_s0);
            if (origin)
                line_base <= '0;
            else if (line_end) begin
                if (frame_end)
                    line_base <= '0;
                else if (fb_row_end)
                    line_base <= line_base + AW'(FB_W);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ND; i++)
                dl[i] <= '0;
        end else begin
            dl[0] <= tap_s0;
            for (int i = 1; i < ND; i++)
                dl[i] <= dl[i-1];
        end
    end

    assign tap_o = dl[ND-1];

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_VIS / 8;
    logic [10:0] sx;
    logic [2:0]  bar;
    logic [11:0] bar_rgb;

    // bar index by threshold compare, avoids a divider
    always_comb begin
        sx  = 11'(tap_o.x) << SCALE_SHIFT;
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (sx >= 11'(k * BAR_W))
                bar = bar + 3'd1;
        bar_rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        pix     = tap_o.pat ? bar_rgb : fb_data;
    end
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign pix = fb_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= 12'h000;
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            {vga_r, vga_g, vga_b} <= tap_o.vis ? pix : 12'h000;
            vga_hsync   <= tap_o.hs ? SYNC_POL : ~SYNC_POL;
            vga_vsync   <= tap_o.vs ? SYNC_POL : ~SYNC_POL;
            frame_start <= tap_o.frm;
        end
    end

endmodule

// File: tb/tb_vga_pixel_out.sv
// Self-checking bench for vga_pixel_out with a line-level reference model.
module tb_vga_pixel_out;
    localparam int RDL  = 1;
    localparam int LAT  = RDL + 1;
    localparam int SC   = 4;
    localparam int FBW  = 200;
    localparam bit POL  = 1'b1;
`ifdef TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic frm;
        logic [11:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [14:0] fb_addr;
    logic        fb_rd_en;
    logic [11:0] fb_data;
    logic        pattern_sel;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [30000];
    pix_t        hist [$];
    pix_t        exp_p;
    logic        exp_rd;
    logic [14:0] exp_addr;

    always #5 clk = ~clk;

    vga_pixel_out #(
        .RD_LATENCY(RDL),
        .SCALE_SHIFT(2),
        .SYNC_POL(POL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hcount(hcount),
        .vcount(vcount),
        .fb_addr(fb_addr),
        .fb_rd_en(fb_rd_en),
        .fb_data(fb_data),
        .pattern_sel(pattern_sel),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .frame_start(frame_start)
    );

    // framebuffer memory with one-cycle read latency
    always @(posedge clk)
        fb_data <= (fb_addr < 15'd30000) ? mem[fb_addr] : 12'h000;

    function automatic pix_t model(input int h, input int v, input logic pat);
        pix_t p;
        logic [2:0] bi;
        p     = '0;
        p.vis = (h < 800) && (v < 600);
        p.hs  = (h >= 840) && (h < 968);
        p.vs  = (v >= 601) && (v < 605);
        p.frm = (h == 0) && (v == 0);
        if (p.vis) begin
            if (pat && PAT_EN) begin
                bi    = 3'(((h / SC) * SC) / 100);
                p.rgb = {{4{bi[2]}}, {4{bi[1]}}, {4{bi[0]}}};
            end else begin
                p.rgb = mem[(v / SC) * FBW + h / SC];
            end
        end
        return p;
    endfunction

    task automatic flush_model();
        hist.delete();
        repeat (LAT) hist.push_back(pix_t'(0));
        exp_rd   = 1'b0;
        exp_addr = '0;
    endtask

    task automatic step(input int h, input int v);
        pix_t p;
        hcount = 11'(h);
        vcount = 10'(v);
        @(posedge clk);
        #1;
        p      = model(h, v, pattern_sel);
        exp_rd = p.vis && !(pattern_sel && PAT_EN);
        if (exp_rd)
            exp_addr = 15'((v / SC) * FBW + h / SC);
        hist.push_back(p);
        exp_p = hist.pop_front();
    endtask

    task automatic hold_reset(input int n);
        reset  = 1'b1;
        hcount = '0;
        vcount = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int pulses;
        hold_reset(3);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b});
        end
        checks++;
        if (vga_hsync !== ~POL) begin
            errors++;
            $display("FAIL reset_hsync got %b want %b", vga_hsync, ~POL);
        end
        checks++;
        if (vga_vsync !== ~POL) begin
            errors++;
            $display("FAIL reset_vsync got %b want %b", vga_vsync, ~POL);
        end
        checks++;
        if (fb_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_en got %b want 0", fb_rd_en);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame got %b want 0", frame_start);
        end
        checks++;
        if (fb_addr !== 15'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d want 0", fb_addr);
        end
        reset = 1'b0;
        flush_model();
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step(k, 0);
            if (frame_start === 1'b1) pulses++;
            checks++;
            if (frame_start !== (k == LAT)) begin
                errors++;
                $display("FAIL frame_start step %0d got %b want %b",
                         k, frame_start, (k == LAT));
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL frame_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_addr();
        step(5, 0);
        checks++;
        if (fb_rd_en !== 1'b1 || fb_addr !== 15'd1) begin
            errors++;
            $display("FAIL addr_h5 got en=%b addr=%0d want en=1 addr=1",
                     fb_rd_en, fb_addr);
        end
        for (int v = 0; v < 4; v++) step(1055, v);
        step(0, 4);
        checks++;
        if (fb_addr !== 15'd200) begin
            errors++;
            $display("FAIL addr_v4 got %0d want 200", fb_addr);
        end
        for (int v = 4; v < 599; v++) step(1055, v);
        step(799, 599);
        checks++;
        if (fb_addr !== 15'd29999) begin
            errors++;
            $display("FAIL addr_last got %0d want 29999", fb_addr);
        end
        for (int v = 599; v < 628; v++) step(1055, v);
        step(2, 0);
        checks++;
        if (fb_addr !== 15'd0 || fb_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL addr_wrap got en=%b addr=%0d want en=1 addr=0",
                     fb_rd_en, fb_addr);
        end
    endtask

    task automatic test_data();
        repeat (3) step(10, 0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'hF0A) begin
            errors++;
            $display("FAIL data_rgb got %h want f0a", {vga_r, vga_g, vga_b});
        end
        step(800, 0);
        checks++;
        if (fb_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL data_h800_en got %b want 0", fb_rd_en);
        end
        repeat (2) step(800, 0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            errors++;
            $display("FAIL data_h800_rgb got %h want 000", {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_hsync();
        int highs;
        int first;
        highs = 0;
        first = -1;
        for (int i = 0; i < 133; i++) begin
            step((i < 131) ? 839 + i : 970, 0);
            if (vga_hsync === POL) begin
                highs++;
                if (first < 0) first = i;
            end
            checks++;
            if (vga_hsync !== (exp_p.hs ? POL : ~POL)) begin
                errors++;
                $display("FAIL hsync_sweep i=%0d got %b want %b",
                         i, vga_hsync, exp_p.hs ? POL : ~POL);
            end
        end
        checks++;
        if (highs != 128 || first != 3) begin
            errors++;
            $display("FAIL hsync_width got %0d@%0d want 128@3", highs, first);
        end
    endtask

    task automatic test_vsync();
        int highs;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, (i < 6) ? 600 + i : 606);
            if (vga_vsync === POL) highs++;
            checks++;
            if (vga_vsync !== (exp_p.vs ? POL : ~POL)) begin
                errors++;
                $display("FAIL vsync_sweep i=%0d got %b want %b",
                         i, vga_vsync, exp_p.vs ? POL : ~POL);
            end
        end
        checks++;
        if (highs != 4) begin
            errors++;
            $display("FAIL vsync_lines got %0d want 4", highs);
        end
    endtask

    task automatic test_overrun();
        step(1056, 10);
        checks++;
        if (fb_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL overrun_en got %b want 0", fb_rd_en);
        end
        repeat (2) step(1056, 10);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hsync !== ~POL) begin
            errors++;
            $display("FAIL overrun_pins got rgb=%h hs=%b want rgb=000 hs=%b",
                     {vga_r, vga_g, vga_b}, vga_hsync, ~POL);
        end
        repeat (3) step(1100, 700);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync} !== {12'h000, ~POL, ~POL}) begin
            errors++;
            $display("FAIL overrun_v got rgb=%h hs=%b vs=%b",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync);
        end
    endtask

    task automatic test_random_scan(input int v_lo, input int v_hi);
        int hq [$];
        int h;
        for (int v = v_lo; v <= v_hi; v++) begin
            hq.delete();
            h = (v == v_lo) ? 0 : int'($urandom_range(0, 40));
            while (h < 1055) begin
                hq.push_back(h);
                h += int'($urandom_range(1, 120));
            end
            hq.push_back(1055);
            pattern_sel = PAT_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            foreach (hq[j]) begin
                step(hq[j], v);
                checks++;
                if (fb_rd_en !== exp_rd) begin
                    errors++;
                    $display("FAIL scan_rd v=%0d h=%0d got %b want %b",
                             v, hq[j], fb_rd_en, exp_rd);
                end
                checks++;
                if (fb_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL scan_addr v=%0d h=%0d got %0d want %0d",
                             v, hq[j], fb_addr, exp_addr);
                end
                checks++;
                if ({vga_r, vga_g, vga_b} !== exp_p.rgb) begin
                    errors++;
                    $display("FAIL scan_rgb v=%0d h=%0d got %h want %h",
                             v, hq[j], {vga_r, vga_g, vga_b}, exp_p.rgb);
                end
                checks++;
                if (vga_hsync !== (exp_p.hs ? POL : ~POL)) begin
                    errors++;
                    $display("FAIL scan_hsync v=%0d h=%0d got %b", v, hq[j], vga_hsync);
                end
                checks++;
                if (vga_vsync !== (exp_p.vs ? POL : ~POL)) begin
                    errors++;
                    $display("FAIL scan_vsync v=%0d h=%0d got %b", v, hq[j], vga_vsync);
                end
                checks++;
                if (frame_start !== exp_p.frm) begin
                    errors++;
                    $display("FAIL scan_frame v=%0d h=%0d got %b want %b",
                             v, hq[j], frame_start, exp_p.frm);
                end
            end
        end
        pattern_sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        test_random_scan(0, 57);
        repeat (3) step(300, 58);
        hold_reset(2);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, fb_rd_en, frame_start}
            !== {12'h000, ~POL, ~POL, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_pins got rgb=%h hs=%b vs=%b en=%b fs=%b",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, fb_rd_en, frame_start);
        end
        reset = 1'b0;
        flush_model();
        test_random_scan(0, 9);
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        pattern_sel = 1'b1;
        step(350, 20);
        checks++;
        if (fb_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL pattern_en got %b want 0", fb_rd_en);
        end
        repeat (2) step(350, 20);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h0FF) begin
            errors++;
            $display("FAIL pattern_bar3 got %h want 0ff", {vga_r, vga_g, vga_b});
        end
        repeat (3) step(799, 20);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
            errors++;
            $display("FAIL pattern_bar7 got %h want fff", {vga_r, vga_g, vga_b});
        end
        pattern_sel = 1'b0;
    endtask
`endif

    initial begin
        reset       = 1'b1;
        hcount      = '0;
        vcount      = '0;
        pattern_sel = 1'b0;
        for (int i = 0; i < 30000; i++)
            mem[i] = 12'($urandom);
        mem[2] = 12'hF0A;
        flush_model();
        test_reset();
        test_addr();
        test_data();
        test_hsync();
        test_vsync();
        test_overrun();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        test_random_scan(0, 627);
        test_random_scan(0, 12);
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
